kim1_display_keypad: RTL and testbench

- Board-side peripheral stage wired to the 6530-002 port pins on the KIM-1 build.
- Consumes PAO/DDRA/PBO/DDRB and demultiplexes the monitor's scanned 6-digit 7-segment display into stable per-digit latches with persistence.
- Also drives the 6530 PAI bus from a debounced host keypad, emulating the 3x7 key matrix selected through PB4..PB1.

---
 rtl/kim1_pkg.sv | 14 +
 rtl/kim1_key_debounce.sv | 42 ++++
 rtl/kim1_display_keypad.sv | 94 +++++++++
 tb/tb_kim1_display_keypad.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/kim1_pkg.sv
// Shared constants and types for the KIM-1 display/keypad board stage.
package kim1_pkg;

    localparam int KIM_NUM_DIGITS     = 6;
    localparam int KIM_DIGIT_SEL_BASE = 4;
    localparam int KIM_NUM_ROWS       = 3;
    localparam int KIM_ROW_KEYS       = 7;

    localparam logic [4:0] KIM_KEY_NONE = 5'h1F;
    localparam logic [3:0] KIM_SEL_NONE = 4'hF;

    typedef logic [6:0] seg7_t;

endpackage

// File: rtl/kim1_key_debounce.sv
// Debounces the host key index into a stable pressed key.
module kim1_key_debounce
    import kim1_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int DCNT_W          = 8
) (
    input  logic       phi2,
    input  logic       rst,
    input  logic       key_down,
    input  logic [4:0] key_idx,
    output logic [4:0] pressed,
    output logic       key_valid
);

    localparam logic [DCNT_W-1:0] CNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]        raw;
    logic [4:0]        cand;
    logic [DCNT_W-1:0] cnt;

    assign raw = (key_down && key_idx <= 5'd20) ? key_idx : KIM_KEY_NONE;

    // cnt parks at CNT_MAX while raw stays put, so pressed keeps reloading
    always_ff @(posedge phi2 or posedge rst) begin
        if (rst) begin
            cand      <= KIM_KEY_NONE;
            cnt       <= '0;
            pressed   <= KIM_KEY_NONE;
            key_valid <= 1'b0;
        end else if (raw != cand) begin
            cand <= raw;
            cnt  <= '0;
        end else if (cnt == CNT_MAX) begin
            pressed   <= cand;
            key_valid <= (cand != KIM_KEY_NONE);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/kim1_display_keypad.sv
// Demultiplexes the scanned 6-digit display into persistent latches
// and emulates the 3x7 keypad matrix on the 6530 port A inputs.
module kim1_display_keypad
    import kim1_pkg::*;
#(
    parameter int PERSIST_CYCLES  = 20000,
    parameter int PCNT_W          = 16,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int DCNT_W          = 8
) (
    input  logic        phi2,
    input  logic        rst,
    input  logic [7:0]  PAO,
    input  logic [7:0]  DDRA,
    input  logic [7:0]  PBO,
    input  logic [7:0]  DDRB,
    input  logic        key_down,
    input  logic [4:0]  key_idx,
    output logic [7:0]  PAI,
    output logic [41:0] seg,
    output logic [5:0]  digit_lit,
    output logic        key_valid
);

    localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(PERSIST_CYCLES);
    localparam logic [PCNT_W-1:0] PCNT_ONE  = PCNT_W'(1);

    logic [3:0] sel;
    seg7_t      m;
    logic [4:0] pressed;
    logic [2:0] row;
    logic [2:0] col;
    logic       unused;

    assign sel = (DDRB[4:1] == 4'hF) ? PBO[4:1] : KIM_SEL_NONE;
    assign m   = PAO[6:0] & DDRA[6:0];

    assign unused = ^{PAO[7], DDRA[7], PBO[7:5], PBO[0], DDRB[7:5], DDRB[0]};

    for (genvar d = 0; d < KIM_NUM_DIGITS; d++) begin : g_digit
        seg7_t             seg_q;
        logic [PCNT_W-1:0] cnt;
        logic              lit_q;
        logic              cap;

        // a blank pattern is the monitor's inter-digit gap, not a digit
        assign cap = (sel == 4'(KIM_DIGIT_SEL_BASE + d)) && (m != '0);

        always_ff @(posedge phi2 or posedge rst) begin
            if (rst) begin
                seg_q <= '0;
                cnt   <= '0;
                lit_q <= 1'b0;
            end else if (cap) begin
                seg_q <= m;
                cnt   <= PCNT_LOAD;
                lit_q <= 1'b1;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
                if (cnt == PCNT_ONE) begin
                    seg_q <= '0;
                    lit_q <= 1'b0;
                end
            end
        end

        assign seg[7*d +: 7] = seg_q;
        assign digit_lit[d]  = lit_q;
    end

    kim1_key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DCNT_W         (DCNT_W)
    ) u_debounce (
        .phi2     (phi2),
        .rst      (rst),
        .key_down (key_down),
        .key_idx  (key_idx),
        .pressed  (pressed),
        .key_valid(key_valid)
    );

    assign row = 3'(pressed / 5'(KIM_ROW_KEYS));
    assign col = 3'(pressed % 5'(KIM_ROW_KEYS));

    // combinational so a PA read right after the PB write sees the row
    always_comb begin
        PAI = 8'hFF;
        if (key_valid && sel == {1'b0, row}) begin
            PAI[col] = 1'b0;
        end
    end

endmodule

// File: tb/tb_kim1_display_keypad.sv
// Randomized self-checking bench for kim1_display_keypad against a
// time-stamp display model and a stable-run-length key model.
module tb_kim1_display_keypad;

    localparam int P = 8;
    localparam int D = 4;

    logic        phi2 = 1'b0;
    logic        rst;
    logic [7:0]  PAO, DDRA, PBO, DDRB;
    logic        key_down;
    logic [4:0]  key_idx;
    logic [7:0]  PAI;
    logic [41:0] seg;
    logic [5:0]  digit_lit;
    logic        key_valid;

    int n_vec = 0;
    int n_bad = 0;

    int         cyc;
    int         last_cap [6];
    logic [6:0] val [6];
    logic [4:0] m_prev_raw;
    int         m_run;
    logic [4:0] m_pressed;

    logic [6:0] pat [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};

    always #5 phi2 = ~phi2;

    kim1_display_keypad #(
        .PERSIST_CYCLES (P),
        .PCNT_W         (16),
        .DEBOUNCE_CYCLES(D),
        .DCNT_W         (8)
    ) dut (
        .phi2     (phi2),
        .rst      (rst),
        .PAO      (PAO),
        .DDRA     (DDRA),
        .PBO      (PBO),
        .DDRB     (DDRB),
        .key_down (key_down),
        .key_idx  (key_idx),
        .PAI      (PAI),
        .seg      (seg),
        .digit_lit(digit_lit),
        .key_valid(key_valid)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [3:0] sel_of();
        return (DDRB[4:1] == 4'hF) ? PBO[4:1] : 4'hF;
    endfunction

    function automatic logic [4:0] raw_of();
        return (key_down && key_idx <= 5'd20) ? key_idx : 5'h1F;
    endfunction

    function automatic logic [41:0] exp_seg();
        logic [41:0] s;
        s = '0;
        for (int d = 0; d < 6; d++)
            if (cyc - last_cap[d] < P) s[7*d +: 7] = val[d];
        return s;
    endfunction

    function automatic logic [5:0] exp_lit();
        logic [5:0] l;
        l = '0;
        for (int d = 0; d < 6; d++) l[d] = (cyc - last_cap[d] < P);
        return l;
    endfunction

    function automatic logic [7:0] exp_pai();
        logic [7:0] p;
        p = 8'hFF;
        if (m_pressed != 5'h1F && int'(sel_of()) == int'(m_pressed) / 7)
            p[int'(m_pressed) % 7] = 1'b0;
        return p;
    endfunction

    task automatic m_reset();
        for (int d = 0; d < 6; d++) begin
            last_cap[d] = -1000;
            val[d]      = '0;
        end
        m_prev_raw = 5'h1F;
        m_run      = 0;
        m_pressed  = 5'h1F;
    endtask

    task automatic check_all();
        check("seg", seg, exp_seg());
        check("digit_lit", digit_lit, exp_lit());
        check("key_valid", key_valid, m_pressed != 5'h1F);
        check("pai", PAI, exp_pai());
    endtask

    task automatic tick();
        logic [3:0] s;
        logic [6:0] mm;
        logic [4:0] r;
        @(posedge phi2);
        cyc++;
        s  = sel_of();
        mm = PAO[6:0] & DDRA[6:0];
        if (s >= 4 && s <= 9 && mm != 0) begin
            last_cap[s-4] = cyc;
            val[s-4]      = mm;
        end
        r = raw_of();
        if (r == m_prev_raw) m_run++;
        else begin
            m_prev_raw = r;
            m_run      = 1;
        end
        if (m_run >= D + 1) m_pressed = r;
        #1;
        check_all();
    endtask

    task automatic drive(input logic [7:0] pao, input logic [7:0] ddra,
                         input logic [7:0] pbo, input logic [7:0] ddrb,
                         input logic kd, input logic [4:0] ki);
        PAO      = pao;
        DDRA     = ddra;
        PBO      = pbo;
        DDRB     = ddrb;
        key_down = kd;
        key_idx  = ki;
        #1;
        check("pai_comb", PAI, exp_pai());
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        m_reset();
        check("rst_seg", seg, 42'h0);
        check("rst_lit", digit_lit, 6'h0);
        check("rst_kv", key_valid, 1'b0);
        check("rst_pai", PAI, 8'hFF);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        PAO = 0; DDRA = 0; PBO = 0; DDRB = 0;
        key_down = 0; key_idx = 0;
        cyc = 0;
        m_reset();
        #2;
        check("init_pai", PAI, 8'hFF);
        check("init_seg", seg, 42'h0);
        check("init_lit", digit_lit, 6'h0);
        check("init_kv", key_valid, 1'b0);
        #10;
        rst = 1'b0;
        repeat (3) tick();

        drive(8'h3F, 8'h7F, 8'h08, 8'h1E, 1'b0, 5'd0);
        tick();
        check("d0_cap_seg", seg[6:0], 7'h3F);
        check("d0_cap_lit", digit_lit[0], 1'b1);
        drive(8'h00, 8'h7F, 8'h08, 8'h1E, 1'b0, 5'd0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("d0_hold", digit_lit[0], 1'b1);
        end
        tick();
        check("d0_exp_lit", digit_lit[0], 1'b0);
        check("d0_exp_seg", seg[6:0], 7'h00);

        for (int i = 0; i < 6; i++) begin
            drive({1'b0, pat[i]}, 8'h7F, 8'((4 + i) << 1), 8'h1E, 1'b0, 5'd0);
            tick();
        end
        drive(8'h00, 8'h7F, 8'h00, 8'h1E, 1'b0, 5'd0);
        tick();
        for (int i = 0; i < 6; i++) check("scan_seg", seg[7*i +: 7], pat[i]);
        drive(8'h7F, 8'h00, 8'h0A, 8'h1E, 1'b0, 5'd0);
        tick();
        check("mask_d1", seg[13:7], 7'h5B);

        drive(8'h77, 8'h7F, 8'h0C, 8'h1E, 1'b0, 5'd0);
        tick();
        drive(8'h00, 8'h7F, 8'h0C, 8'h1E, 1'b0, 5'd0);
        repeat (7) tick();
        drive(8'h4F, 8'h7F, 8'h0C, 8'h1E, 1'b0, 5'd0);
        tick();
        check("d2_reload_lit", digit_lit[2], 1'b1);
        check("d2_reload_seg", seg[20:14], 7'h4F);
        drive(8'h00, 8'h7F, 8'h0C, 8'h1E, 1'b0, 5'd0);
        repeat (7) begin
            tick();
            check("d2_hold", digit_lit[2], 1'b1);
        end
        tick();
        check("d2_expire", digit_lit[2], 1'b0);

        drive(8'h00, 8'h7F, 8'h00, 8'h1E, 1'b1, 5'd9);
        repeat (4) begin
            tick();
            check("kv_wait", key_valid, 1'b0);
        end
        tick();
        check("kv_rise", key_valid, 1'b1);
        drive(8'h00, 8'h7F, 8'h02, 8'h1E, 1'b1, 5'd9);
        check("pai_row1", PAI, 8'hFB);
        drive(8'h00, 8'h7F, 8'h00, 8'h1E, 1'b1, 5'd9);
        check("pai_row0", PAI, 8'hFF);
        drive(8'h00, 8'h7F, 8'h02, 8'h1E, 1'b1, 5'd10);
        repeat (2) tick();
        drive(8'h00, 8'h7F, 8'h02, 8'h1E, 1'b1, 5'd9);
        tick();
        check("glitch_kv", key_valid, 1'b1);
        check("glitch_pai", PAI, 8'hFB);
        repeat (6) tick();

        drive(8'h00, 8'h7F, 8'h02, 8'h1E, 1'b1, 5'd25);
        repeat (4) begin
            tick();
            check("none_wait", key_valid, 1'b1);
        end
        tick();
        check("none_fall", key_valid, 1'b0);

        drive(8'h00, 8'h7F, 8'h02, 8'h1E, 1'b1, 5'd9);
        repeat (6) tick();
        drive(8'h00, 8'h7F, 8'h02, 8'h1C, 1'b1, 5'd9);
        check("ddrb_off_pai", PAI, 8'hFF);
        drive(8'h00, 8'h7F, 8'h02, 8'h1E, 1'b1, 5'd9);
        check("ddrb_on_pai", PAI, 8'hFB);

        for (int i = 0; i < 3; i++) begin
            drive({1'b0, pat[i]}, 8'h7F, 8'((4 + i) << 1), 8'h1E, 1'b1, 5'd9);
            tick();
        end
        check("pre_rst_lit", digit_lit[2:0], 3'b111);
        async_reset();
        repeat (2) tick();

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] pao, ddra, pbo, ddrb;
            logic       kd;
            logic [4:0] ki;
            pao  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            ddra = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'hFF;
            pbo  = 8'($urandom);
            ddrb = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h1E;
            kd   = key_down;
            ki   = key_idx;
            if ($urandom_range(0, 7) == 0) begin
                kd = ($urandom_range(0, 3) != 0);
                ki = 5'($urandom_range(0, 24));
            end
            drive(pao, ddra, pbo, ddrb, kd, ki);
            tick();
            if ($urandom_range(0, 499) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
